reg_bank_shadow: RTL and testbench

Parametrised multi-register successor to the single enable-gated register primitive. It holds nregs registers of width bits, each with a byte-lane-writable shadow copy and an active copy. A COMMIT pulse atomically transfers all pending shadow values to the active copies, and an ABORT pulse discards them. It sits between a configuration write port (CSR/bus side) and datapath logic that must see only whole, consistent register sets.

---
 rtl/reg_bank_shadow.sv | 133 +++++++++++++
 tb/tb_reg_bank_shadow.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_shadow.sv
// reg_bank_shadow: bank of nregs registers, each with a byte-lane-writable
// shadow copy and an active copy. COMMIT copies dirty shadows to active in one
// edge. ABORT restores every shadow from its active copy.
//
// Ports:
//   CLK, RST      clock (posedge), asynchronous active-high reset
//   WR_*          shadow write port (strobe, index, data, byte enables)
//   COMMIT/ABORT  bank-wide transfer controls; COMMIT has priority
//   RD_*          registered read port, 1-cycle latency, shadow/active select
//   Q_OUT         all active values, register i at [i*width +: width]
//   DIRTY         per-register pending-write flags
//   COMMIT_ACK    pulse the cycle after a commit
//   ERR           pulse the cycle after an out-of-range access
//   COMMIT_COUNT  wrapping commit counter
module reg_bank_shadow #(
    parameter int              width      = 32,
    parameter int              nregs      = 4,
    parameter int              addr_width = 2,
    parameter logic [width-1:0] init      = '0
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    WR_EN,
    input  logic [addr_width-1:0]   WR_ADDR,
    input  logic [width-1:0]        WR_DATA,
    input  logic [width/8-1:0]      WR_BE,
    input  logic                    COMMIT,
    input  logic                    ABORT,
    input  logic                    RD_EN,
    input  logic [addr_width-1:0]   RD_ADDR,
    input  logic                    RD_SHADOW,
    output logic [width-1:0]        RD_DATA,
    output logic                    RD_VALID,
    output logic [nregs*width-1:0]  Q_OUT,
    output logic [nregs-1:0]        DIRTY,
    output logic                    COMMIT_ACK,
    output logic                    ERR,
    output logic [7:0]              COMMIT_COUNT
);

    localparam int nbytes = width / 8;
    // One extra bit so that nregs == 2**addr_width is representable.
    localparam logic [addr_width:0] nregs_lim = (addr_width + 1)'(nregs);

    logic [width-1:0] shadow_q [nregs];
    logic [width-1:0] active_q [nregs];
    logic [width-1:0] shadow_d [nregs];
    logic [width-1:0] active_d [nregs];
    logic [nregs-1:0] dirty_d;
    logic [width-1:0] be_mask;
    logic [width-1:0] rd_sel;
    logic             wr_in_range;
    logic             rd_in_range;
    logic             wr_ok;
    logic             abort_eff;

    assign wr_in_range = ({1'b0, WR_ADDR} < nregs_lim);
    assign rd_in_range = ({1'b0, RD_ADDR} < nregs_lim);
    assign wr_ok       = WR_EN && wr_in_range && (WR_BE != '0);
    assign abort_eff   = ABORT && !COMMIT;

    always_comb begin
        be_mask = '0;
        for (int k = 0; k < nbytes; k++) begin
            be_mask[8*k +: 8] = {8{WR_BE[k]}};
        end
    end

    // A same-cycle write is overlaid on whatever the shadow would otherwise
    // become, so write+ABORT yields active with the written bytes on top,
    // and write+COMMIT leaves the new data pending while committing the old.
    always_comb begin
        dirty_d = DIRTY;
        for (int i = 0; i < nregs; i++) begin
            logic [width-1:0] base;
            logic             hit;
            base = abort_eff ? active_q[i] : shadow_q[i];
            hit  = wr_ok && (WR_ADDR == addr_width'(i));
            shadow_d[i] = hit ? ((base & ~be_mask) | (WR_DATA & be_mask)) : base;
            active_d[i] = (COMMIT && DIRTY[i]) ? shadow_q[i] : active_q[i];
            if (hit) begin
                dirty_d[i] = 1'b1;
            end else if (COMMIT || ABORT) begin
                dirty_d[i] = 1'b0;
            end
        end
    end

    // Out-of-range read addresses match no entry and return zero.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < nregs; i++) begin
            if (RD_ADDR == addr_width'(i)) begin
                rd_sel = RD_SHADOW ? shadow_q[i] : active_q[i];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < nregs; i++) begin
                shadow_q[i] <= init;
                active_q[i] <= init;
            end
            DIRTY        <= '0;
            RD_DATA      <= '0;
            RD_VALID     <= 1'b0;
            COMMIT_ACK   <= 1'b0;
            ERR          <= 1'b0;
            COMMIT_COUNT <= '0;
        end else begin
            for (int i = 0; i < nregs; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
            DIRTY      <= dirty_d;
            RD_VALID   <= RD_EN;
            if (RD_EN) begin
                RD_DATA <= rd_sel;
            end
            COMMIT_ACK <= COMMIT;
            ERR        <= (WR_EN && !wr_in_range) || (RD_EN && !rd_in_range);
            if (COMMIT) begin
                COMMIT_COUNT <= COMMIT_COUNT + 8'd1;
            end
        end
    end

    for (genvar g = 0; g < nregs; g++) begin : g_qout
        assign Q_OUT[g*width +: width] = active_q[g];
    end

endmodule

// File: tb/tb_reg_bank_shadow.sv
// Directed testbench for reg_bank_shadow. Main instance has 4 registers; a
// second 3-register instance exercises out-of-range addressing.
module tb_reg_bank_shadow;

    localparam logic [31:0] I = 32'hA5A5_0000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        WR_EN = 0, COMMIT = 0, ABORT = 0, RD_EN = 0, RD_SHADOW = 0;
    logic [1:0]  WR_ADDR = 0, RD_ADDR = 0;
    logic [31:0] WR_DATA = 0;
    logic [3:0]  WR_BE = 0;
    logic [31:0] RD_DATA;
    logic        RD_VALID, COMMIT_ACK, ERR;
    logic [127:0] Q_OUT;
    logic [3:0]  DIRTY;
    logic [7:0]  COMMIT_COUNT;

    logic        wr_en3 = 0, commit3 = 0, abort3 = 0, rd_en3 = 0, rd_shadow3 = 0;
    logic [1:0]  wr_addr3 = 0, rd_addr3 = 0;
    logic [31:0] wr_data3 = 0;
    logic [3:0]  wr_be3 = 0;
    logic [31:0] rd_data3;
    logic        rd_valid3, commit_ack3, err3;
    logic [95:0] q_out3;
    logic [2:0]  dirty3;
    logic [7:0]  commit_count3;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    reg_bank_shadow #(.width(32), .nregs(4), .addr_width(2), .init(I)) dut (
        .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .WR_BE(WR_BE), .COMMIT(COMMIT), .ABORT(ABORT), .RD_EN(RD_EN),
        .RD_ADDR(RD_ADDR), .RD_SHADOW(RD_SHADOW), .RD_DATA(RD_DATA),
        .RD_VALID(RD_VALID), .Q_OUT(Q_OUT), .DIRTY(DIRTY),
        .COMMIT_ACK(COMMIT_ACK), .ERR(ERR), .COMMIT_COUNT(COMMIT_COUNT)
    );

    reg_bank_shadow #(.width(32), .nregs(3), .addr_width(2), .init(I)) dut3 (
        .CLK(CLK), .RST(RST), .WR_EN(wr_en3), .WR_ADDR(wr_addr3), .WR_DATA(wr_data3),
        .WR_BE(wr_be3), .COMMIT(commit3), .ABORT(abort3), .RD_EN(rd_en3),
        .RD_ADDR(rd_addr3), .RD_SHADOW(rd_shadow3), .RD_DATA(rd_data3),
        .RD_VALID(rd_valid3), .Q_OUT(q_out3), .DIRTY(dirty3),
        .COMMIT_ACK(commit_ack3), .ERR(err3), .COMMIT_COUNT(commit_count3)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        WR_EN = 0; COMMIT = 0; ABORT = 0; RD_EN = 0; RD_SHADOW = 0; WR_BE = 0;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        RST = 0;
        tick();
        checks++; if (Q_OUT !== {4{I}}) begin errors++; $display("FAIL reset_q: got %h expected %h", Q_OUT, {4{I}}); end
        checks++; if (DIRTY !== 4'b0) begin errors++; $display("FAIL reset_dirty: got %b expected 0000", DIRTY); end
        checks++; if ({RD_VALID, COMMIT_ACK, ERR} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {RD_VALID, COMMIT_ACK, ERR}); end
        checks++; if (RD_DATA !== 32'h0 || COMMIT_COUNT !== 8'd0) begin errors++; $display("FAIL reset_rd_cnt: got %h/%0d expected 0/0", RD_DATA, COMMIT_COUNT); end
        // Commit something, then pulse reset between edges.
        WR_EN = 1; WR_ADDR = 0; WR_DATA = 32'h1234_5678; WR_BE = 4'hF;
        tick();
        idle(); COMMIT = 1;
        tick();
        idle();
        checks++; if (Q_OUT[31:0] !== 32'h1234_5678) begin errors++; $display("FAIL pre_reset_commit: got %h expected 12345678", Q_OUT[31:0]); end
        #2 RST = 1;
        #1;
        checks++; if (Q_OUT !== {4{I}}) begin errors++; $display("FAIL async_reset_q: got %h expected %h", Q_OUT, {4{I}}); end
        checks++; if (DIRTY !== 4'b0 || COMMIT_COUNT !== 8'd0 || COMMIT_ACK !== 1'b0) begin errors++; $display("FAIL async_reset_state: dirty %b cnt %0d ack %b expected 0 0 0", DIRTY, COMMIT_COUNT, COMMIT_ACK); end
        #1 RST = 0;
        tick();
    endtask

    task automatic test_byte_write_commit();
        WR_EN = 1; WR_ADDR = 2; WR_DATA = 32'h1122_3344; WR_BE = 4'b0101;
        tick();
        idle();
        checks++; if (DIRTY !== 4'b0100) begin errors++; $display("FAIL bw_dirty: got %b expected 0100", DIRTY); end
        checks++; if (Q_OUT[64 +: 32] !== I) begin errors++; $display("FAIL bw_active_held: got %h expected %h", Q_OUT[64 +: 32], I); end
        RD_EN = 1; RD_ADDR = 2; RD_SHADOW = 1;
        tick();
        RD_SHADOW = 0;
        checks++; if (RD_VALID !== 1'b1 || RD_DATA !== 32'hA522_0044) begin errors++; $display("FAIL bw_rd_shadow: got %b/%h expected 1/a5220044", RD_VALID, RD_DATA); end
        tick();
        idle();
        checks++; if (RD_DATA !== I) begin errors++; $display("FAIL bw_rd_active: got %h expected %h", RD_DATA, I); end
        tick();
        checks++; if (RD_VALID !== 1'b0 || RD_DATA !== I) begin errors++; $display("FAIL bw_rd_hold: got %b/%h expected 0/%h", RD_VALID, RD_DATA, I); end
        WR_EN = 1; WR_ADDR = 1; WR_DATA = 32'hFFFF_FFFF; WR_BE = 4'b0;
        tick();
        idle();
        checks++; if (DIRTY !== 4'b0100) begin errors++; $display("FAIL bw_be_zero: got %b expected 0100", DIRTY); end
        COMMIT = 1;
        tick();
        idle();
        checks++; if (Q_OUT[64 +: 32] !== 32'hA522_0044) begin errors++; $display("FAIL bw_commit_q: got %h expected a5220044", Q_OUT[64 +: 32]); end
        checks++; if (Q_OUT[32 +: 32] !== I) begin errors++; $display("FAIL bw_commit_q1: got %h expected %h", Q_OUT[32 +: 32], I); end
        checks++; if (COMMIT_ACK !== 1'b1 || DIRTY !== 4'b0 || COMMIT_COUNT !== 8'd1) begin errors++; $display("FAIL bw_commit_flags: ack %b dirty %b cnt %0d expected 1 0000 1", COMMIT_ACK, DIRTY, COMMIT_COUNT); end
        tick();
        checks++; if (COMMIT_ACK !== 1'b0) begin errors++; $display("FAIL bw_ack_pulse: got %b expected 0", COMMIT_ACK); end
    endtask

    task automatic test_write_with_commit();
        WR_EN = 1; WR_ADDR = 1; WR_DATA = 32'hCAFE_BABE; WR_BE = 4'hF;
        tick();
        WR_DATA = 32'hDEAD_BEEF; COMMIT = 1;
        RD_EN = 1; RD_ADDR = 1; RD_SHADOW = 1;
        tick();
        idle();
        checks++; if (Q_OUT[32 +: 32] !== 32'hCAFE_BABE) begin errors++; $display("FAIL wc_active: got %h expected cafebabe", Q_OUT[32 +: 32]); end
        checks++; if (DIRTY !== 4'b0010 || COMMIT_COUNT !== 8'd2) begin errors++; $display("FAIL wc_dirty_cnt: got %b/%0d expected 0010/2", DIRTY, COMMIT_COUNT); end
        checks++; if (RD_DATA !== 32'hCAFE_BABE) begin errors++; $display("FAIL wc_rd_pre_edge: got %h expected cafebabe", RD_DATA); end
        RD_EN = 1; RD_ADDR = 1; RD_SHADOW = 1;
        tick();
        idle();
        checks++; if (RD_DATA !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wc_shadow: got %h expected deadbeef", RD_DATA); end
        COMMIT = 1;
        tick();
        idle();
        checks++; if (Q_OUT[32 +: 32] !== 32'hDEAD_BEEF || COMMIT_COUNT !== 8'd3) begin errors++; $display("FAIL wc_second_commit: got %h/%0d expected deadbeef/3", Q_OUT[32 +: 32], COMMIT_COUNT); end
    endtask

    task automatic test_abort();
        WR_EN = 1; WR_ADDR = 0; WR_DATA = 32'h0102_0304; WR_BE = 4'hF;
        tick();
        WR_ADDR = 3; WR_DATA = 32'h5566_7788; WR_BE = 4'b1100;
        tick();
        idle();
        checks++; if (DIRTY !== 4'b1001) begin errors++; $display("FAIL ab_dirty_before: got %b expected 1001", DIRTY); end
        RD_EN = 1; RD_ADDR = 3; RD_SHADOW = 1;
        tick();
        idle();
        checks++; if (RD_DATA !== 32'h5566_0000) begin errors++; $display("FAIL ab_shadow3: got %h expected 55660000", RD_DATA); end
        ABORT = 1;
        tick();
        idle();
        checks++; if (DIRTY !== 4'b0 || COMMIT_ACK !== 1'b0 || COMMIT_COUNT !== 8'd3) begin errors++; $display("FAIL ab_flags: dirty %b ack %b cnt %0d expected 0000 0 3", DIRTY, COMMIT_ACK, COMMIT_COUNT); end
        checks++; if (Q_OUT !== {I, 32'hA522_0044, 32'hDEAD_BEEF, I}) begin errors++; $display("FAIL ab_q: got %h expected %h", Q_OUT, {I, 32'hA522_0044, 32'hDEAD_BEEF, I}); end
        RD_EN = 1; RD_ADDR = 0; RD_SHADOW = 1;
        tick();
        checks++; if (RD_DATA !== I) begin errors++; $display("FAIL ab_restore0: got %h expected %h", RD_DATA, I); end
        RD_ADDR = 3;
        tick();
        idle();
        checks++; if (RD_DATA !== I) begin errors++; $display("FAIL ab_restore3: got %h expected %h", RD_DATA, I); end
        // Write landing in the same cycle as ABORT.
        WR_EN = 1; WR_ADDR = 0; WR_DATA = 32'h0A0B_0C0D; WR_BE = 4'hF;
        tick();
        WR_ADDR = 3; WR_DATA = 32'h9988_7766; WR_BE = 4'b0001; ABORT = 1;
        tick();
        idle();
        checks++; if (DIRTY !== 4'b1000) begin errors++; $display("FAIL wa_dirty: got %b expected 1000", DIRTY); end
        RD_EN = 1; RD_ADDR = 3; RD_SHADOW = 1;
        tick();
        RD_ADDR = 0;
        checks++; if (RD_DATA !== 32'hA5A5_0066) begin errors++; $display("FAIL wa_shadow3: got %h expected a5a50066", RD_DATA); end
        tick();
        idle();
        checks++; if (RD_DATA !== I) begin errors++; $display("FAIL wa_shadow0: got %h expected %h", RD_DATA, I); end
        COMMIT = 1; ABORT = 1;
        tick();
        idle();
        checks++; if (Q_OUT[96 +: 32] !== 32'hA5A5_0066) begin errors++; $display("FAIL ca_q3: got %h expected a5a50066", Q_OUT[96 +: 32]); end
        checks++; if (COMMIT_ACK !== 1'b1 || COMMIT_COUNT !== 8'd4 || DIRTY !== 4'b0) begin errors++; $display("FAIL ca_flags: ack %b cnt %0d dirty %b expected 1 4 0000", COMMIT_ACK, COMMIT_COUNT, DIRTY); end
    endtask

    task automatic test_out_of_range();
        wr_en3 = 1; wr_addr3 = 3; wr_data3 = 32'hFFFF_FFFF; wr_be3 = 4'hF;
        tick();
        wr_en3 = 0; wr_be3 = 0;
        checks++; if (err3 !== 1'b1 || dirty3 !== 3'b0 || q_out3 !== {3{I}}) begin errors++; $display("FAIL oor_wr: err %b dirty %b q %h expected 1 000 %h", err3, dirty3, q_out3, {3{I}}); end
        tick();
        checks++; if (err3 !== 1'b0) begin errors++; $display("FAIL oor_err_pulse: got %b expected 0", err3); end
        rd_en3 = 1; rd_addr3 = 2; rd_shadow3 = 1;
        tick();
        checks++; if (rd_valid3 !== 1'b1 || rd_data3 !== I || err3 !== 1'b0) begin errors++; $display("FAIL oor_inrange_rd: %b %h %b expected 1 %h 0", rd_valid3, rd_data3, err3, I); end
        rd_addr3 = 3;
        tick();
        rd_en3 = 0;
        checks++; if (rd_valid3 !== 1'b1 || rd_data3 !== 32'h0 || err3 !== 1'b1) begin errors++; $display("FAIL oor_rd: %b %h %b expected 1 0 1", rd_valid3, rd_data3, err3); end
        tick();
        checks++; if (err3 !== 1'b0 || rd_valid3 !== 1'b0) begin errors++; $display("FAIL oor_rd_after: err %b valid %b expected 0 0", err3, rd_valid3); end
    endtask

    task automatic test_counter_wrap();
        COMMIT = 1;
        repeat (251) tick();
        checks++; if (COMMIT_COUNT !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d expected 255", COMMIT_COUNT); end
        tick();
        checks++; if (COMMIT_COUNT !== 8'd0) begin errors++; $display("FAIL wrap_0: got %0d expected 0", COMMIT_COUNT); end
        repeat (4) tick();
        idle();
        checks++; if (COMMIT_COUNT !== 8'd4) begin errors++; $display("FAIL wrap_256: got %0d expected 4", COMMIT_COUNT); end
    endtask

    task automatic test_reset_mid_op();
        WR_EN = 1; WR_ADDR = 1; WR_DATA = 32'h0; WR_BE = 4'hF;
        COMMIT = 1; RD_EN = 1; RD_ADDR = 1; RD_SHADOW = 0;
        #2 RST = 1;
        #1;
        checks++; if (Q_OUT !== {4{I}} || COMMIT_COUNT !== 8'd0 || RD_DATA !== 32'h0) begin errors++; $display("FAIL mid_reset_async: q %h cnt %0d rd %h", Q_OUT, COMMIT_COUNT, RD_DATA); end
        tick();
        idle();
        RST = 0;
        tick();
        checks++; if (COMMIT_ACK !== 1'b0 || ERR !== 1'b0 || RD_VALID !== 1'b0) begin errors++; $display("FAIL mid_reset_flags: ack %b err %b valid %b expected 000", COMMIT_ACK, ERR, RD_VALID); end
        checks++; if (Q_OUT !== {4{I}} || DIRTY !== 4'b0 || COMMIT_COUNT !== 8'd0) begin errors++; $display("FAIL mid_reset_state: q %h dirty %b cnt %0d", Q_OUT, DIRTY, COMMIT_COUNT); end
    endtask

    initial begin
        test_reset();
        test_byte_write_commit();
        test_write_with_commit();
        test_abort();
        test_out_of_range();
        test_counter_wrap();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
